// File: rtl/register_file_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_multiport
//  Description : Parametrised multi-read-port register file. Reads are
//                combinational. After reset a sequential clear sweep zeroes
//                every entry. out_ready rises once the bank is usable.
//                Options: hardwired-zero register 0, and forwarding of
//                same-cycle write data to the read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_multiport #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         in_write_enable,
  input  logic [AW-1:0]                in_write_register_select,
  input  logic [DATA_W-1:0]            in_write_data,
  input  logic [NUM_READ*AW-1:0]       in_read_register_select,
  output logic [NUM_READ*DATA_W-1:0]   out_read_data,
  output logic                         out_ready
);

  // Index of the last entry swept by the clear, and the entry count widened
  // by one bit so that a power-of-two NUM_REGS still fits.
  localparam logic [AW-1:0] C_LAST_IDX = AW'(NUM_REGS - 1);
  localparam logic [AW:0]   C_NUM_REGS = (AW + 1)'(NUM_REGS);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [AW-1:0]       r_clear_idx;
  logic [AW-1:0]       w_clear_idx_next;
  logic                r_ready;
  logic                w_ready_next;
  logic                w_clear_last;

  logic                w_wsel_in_range;
  logic                w_wsel_is_zero;
  logic                w_write_ok;

  logic [DATA_W-1:0]   r_bank [NUM_REGS];

  assign w_clear_last = (r_clear_idx == C_LAST_IDX);

  // State, clear pointer and ready flag; the only async-reset state
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= ST_INIT;
      r_clear_idx <= '0;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_clear_idx <= w_clear_idx_next;
      r_ready     <= w_ready_next;
    end
  end

  // Next-state: sweep the clear pointer in INIT, leave on the last entry
  always_comb begin
    w_state_next     = r_state;
    w_clear_idx_next = r_clear_idx;
    w_ready_next     = r_ready;
    case (r_state)
      ST_INIT: begin
        w_clear_idx_next = r_clear_idx + AW'(1);
        if (w_clear_last) begin
          w_state_next     = ST_READY;
          w_ready_next     = 1'b1;
          w_clear_idx_next = '0;
        end
      end
      ST_READY: begin
        w_ready_next = 1'b1;
      end
      default: begin
        w_state_next     = ST_INIT;
        w_clear_idx_next = '0;
        w_ready_next     = 1'b0;
      end
    endcase
  end

  assign out_ready = r_ready;

  // Write qualification: only in READY, in-range index, never to a hardwired zero
  always_comb begin
    w_wsel_in_range = ({1'b0, in_write_register_select} < C_NUM_REGS);
    w_wsel_is_zero  = ZERO_REG && (in_write_register_select == '0);
    w_write_ok      = in_write_enable && (r_state == ST_READY) &&
                      w_wsel_in_range && !w_wsel_is_zero;
  end

  // Storage: zero one entry per cycle during INIT, accept qualified writes after.
  // Contents are deliberately not reset; the clear sweep handles that.
  always_ff @(posedge CLK) begin
    if (r_state == ST_INIT) begin
      r_bank[r_clear_idx] <= '0;
    end else if (w_write_ok) begin
      r_bank[in_write_register_select] <= in_write_data;
    end
  end

  // One independent combinational read mux per port
  for (genvar p = 0; p < NUM_READ; p++) begin : g_read
    logic [AW-1:0]     w_rsel;
    logic [DATA_W-1:0] w_rdata;

    assign w_rsel = in_read_register_select[p*AW +: AW];

    // Priority: clearing, out of range, hardwired zero, forward, stored value
    always_comb begin
      w_rdata = '0;
      if (r_state == ST_INIT) begin
        w_rdata = '0;
      end else if ({1'b0, w_rsel} >= C_NUM_REGS) begin
        w_rdata = '0;
      end else if (ZERO_REG && (w_rsel == '0)) begin
        w_rdata = '0;
      end else if (BYPASS && in_write_enable &&
                   (in_write_register_select == w_rsel)) begin
        w_rdata = in_write_data;
      end else begin
        w_rdata = r_bank[w_rsel];
      end
    end

    assign out_read_data[p*DATA_W +: DATA_W] = w_rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file_multiport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_multiport
//  Description : Self-checking bench for register_file_multiport. Drives a
//                default instance and a small, non-power-of-two instance
//                without zero register or forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_multiport;

  logic        CLK;
  logic        RESET;

  // Instance 1: defaults (32 x 32b, 3 read ports, zero reg, bypass)
  logic        we1;
  logic [4:0]  wsel1;
  logic [31:0] wdata1;
  logic [14:0] rsel1;
  logic [95:0] out1;
  logic        rdy1;

  // Instance 2: 24 x 16b, 2 read ports, no zero reg, no bypass
  logic        we2;
  logic [4:0]  wsel2;
  logic [15:0] wdata2;
  logic [9:0]  rsel2;
  logic [31:0] out2;
  logic        rdy2;

  int checks;
  int errors;

  // Reference model: cycles since reset release and plain array contents
  int          cyc1;
  int          cyc2;
  logic [31:0] m1 [32];
  logic [15:0] m2 [24];

  register_file_multiport dut1 (
    .CLK                      (CLK),
    .RESET                    (RESET),
    .in_write_enable          (we1),
    .in_write_register_select (wsel1),
    .in_write_data            (wdata1),
    .in_read_register_select  (rsel1),
    .out_read_data            (out1),
    .out_ready                (rdy1)
  );

  register_file_multiport #(
    .DATA_W   (16),
    .NUM_REGS (24),
    .NUM_READ (2),
    .ZERO_REG (1'b0),
    .BYPASS   (1'b0)
  ) dut2 (
    .CLK                      (CLK),
    .RESET                    (RESET),
    .in_write_enable          (we2),
    .in_write_register_select (wsel2),
    .in_write_data            (wdata2),
    .in_read_register_select  (rsel2),
    .out_read_data            (out2),
    .out_ready                (rdy2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc1 = 0;
    cyc2 = 0;
    foreach (m1[i]) m1[i] = '0;
    foreach (m2[i]) m2[i] = '0;
  endtask

  function automatic logic [31:0] exp1(input logic [4:0] sel);
    if (cyc1 < 32) return 32'h0;
    if (sel == 5'd0) return 32'h0;
    if (we1 && (wsel1 == sel)) return wdata1;
    return m1[sel];
  endfunction

  function automatic logic [31:0] exp2(input logic [4:0] sel);
    if (cyc2 < 24) return 32'h0;
    if (sel >= 5'd24) return 32'h0;
    return {16'h0, m2[sel]};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_rdy1"}, {31'h0, rdy1}, {31'h0, (cyc1 >= 32)});
    for (int p = 0; p < 3; p++)
      chk($sformatf("%s_d1p%0d", tag, p), out1[p*32 +: 32], exp1(rsel1[p*5 +: 5]));
    chk({tag, "_rdy2"}, {31'h0, rdy2}, {31'h0, (cyc2 >= 24)});
    for (int p = 0; p < 2; p++)
      chk($sformatf("%s_d2p%0d", tag, p), {16'h0, out2[p*16 +: 16]}, exp2(rsel2[p*5 +: 5]));
  endtask

  task automatic model_advance();
    if (cyc1 < 32) cyc1++;
    else if (we1 && (wsel1 != 5'd0)) m1[wsel1] = wdata1;
    if (cyc2 < 24) cyc2++;
    else if (we2 && (wsel2 < 5'd24)) m2[wsel2] = wdata2;
  endtask

  // Check outputs mid-cycle, then let the model see the same rising edge
  task automatic cycle(input string tag);
    @(negedge CLK);
    check_all(tag);
    @(posedge CLK);
    if (RESET) model_advance();
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESET  = 1'b0;
    we1 = 1'b0; wsel1 = '0; wdata1 = '0; rsel1 = '0;
    we2 = 1'b0; wsel2 = '0; wdata2 = '0; rsel2 = '0;
    model_reset();

    // Held in reset: not ready, all reads zero
    rsel1 = {5'd3, 5'd2, 5'd1};
    repeat (2) cycle("rst");
    #1;
    chk("rst_ready", {31'h0, rdy1}, 32'h0);
    RESET = 1'b1;

    // Clear sweep: 32 cycles not ready; a write in cycle 10 must be dropped
    for (int i = 0; i < 32; i++) begin
      we1   = (i == 10);
      wsel1 = 5'd3;
      wdata1 = 32'hAA;
      rsel1 = {5'(i), 5'd3, 5'(31 - i)};
      #1;
      chk("init_ready_low", {31'h0, rdy1}, 32'h0);
      chk("init_read_zero", out1[63:32], 32'h0);
      cycle("init");
    end
    we1 = 1'b0;
    #1;
    chk("init_ready_high", {31'h0, rdy1}, 32'h1);

    // Write during INIT was dropped
    rsel1 = {5'd0, 5'd0, 5'd3};
    #1;
    chk("init_write_dropped", out1[31:0], 32'h0);
    cycle("t5");

    // Write r5, then read it on two ports
    we1 = 1'b1; wsel1 = 5'd5; wdata1 = 32'hDEADBEEF;
    cycle("t2w");
    we1 = 1'b0;
    rsel1 = {5'd5, 5'd3, 5'd5};
    #1;
    chk("r5_port0", out1[31:0], 32'hDEADBEEF);
    chk("r5_port2", out1[95:64], 32'hDEADBEEF);
    cycle("t2r");

    // Forwarding on instance 1, none on instance 2
    we1 = 1'b1; wsel1 = 5'd7; wdata1 = 32'h1234; rsel1 = {5'd0, 5'd7, 5'd0};
    we2 = 1'b1; wsel2 = 5'd7; wdata2 = 16'h1234; rsel2 = {5'd0, 5'd7};
    #1;
    chk("bypass_same_cycle", out1[63:32], 32'h1234);
    chk("nobypass_old", {16'h0, out2[15:0]}, 32'h0);
    cycle("t3w");
    we1 = 1'b0; we2 = 1'b0;
    #1;
    chk("bypass_next_cycle", out1[63:32], 32'h1234);
    chk("nobypass_new", {16'h0, out2[15:0]}, 32'h1234);
    cycle("t3r");

    // Register 0 hardwired on instance 1, ordinary on instance 2
    we1 = 1'b1; wsel1 = 5'd0; wdata1 = 32'hFFFFFFFF; rsel1 = {5'd0, 5'd0, 5'd0};
    we2 = 1'b1; wsel2 = 5'd0; wdata2 = 16'h55AA;     rsel2 = {5'd0, 5'd0};
    #1;
    chk("zero_write_cycle", out1[31:0], 32'h0);
    cycle("t4w");
    we1 = 1'b0; we2 = 1'b0;
    #1;
    chk("zero_after", out1[31:0], 32'h0);
    chk("r0_normal", {16'h0, out2[31:16]}, 32'h55AA);
    cycle("t4r");

    // Out-of-range write and read on the 24-entry instance
    we2 = 1'b1; wsel2 = 5'd30; wdata2 = 16'hBEEF; rsel2 = {5'd30, 5'd23};
    #1;
    chk("oor_read_wcycle", {16'h0, out2[31:16]}, 32'h0);
    cycle("oorw");
    we2 = 1'b0;
    #1;
    chk("oor_read_after", {16'h0, out2[31:16]}, 32'h0);
    cycle("oorr");

    // Reset mid-INIT restarts the full clear
    we1 = 1'b1; wsel1 = 5'd9; wdata1 = 32'h900D; rsel1 = {5'd9, 5'd0, 5'd0};
    cycle("t6w");
    we1 = 1'b0;
    #1;
    chk("r9_written", out1[95:64], 32'h900D);
    RESET = 1'b0;
    model_reset();
    #1;
    chk("rst_async_ready", {31'h0, rdy1}, 32'h0);
    chk("rst_async_read", out1[95:64], 32'h0);
    cycle("t6r0");
    RESET = 1'b1;
    repeat (20) cycle("t6a");
    RESET = 1'b0;
    model_reset();
    cycle("t6r1");
    RESET = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("reinit_ready_low", {31'h0, rdy1}, 32'h0);
      cycle("t6b");
    end
    #1;
    chk("reinit_ready_high", {31'h0, rdy1}, 32'h1);
    chk("r9_cleared", out1[95:64], 32'h0);

    // Randomised traffic against the model, with rare resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        RESET = 1'b0;
        model_reset();
        cycle("rnd_rst");
        RESET = 1'b1;
      end
      we1    = 1'($urandom_range(0, 1));
      wsel1  = 5'($urandom_range(0, 31));
      wdata1 = $urandom;
      for (int p = 0; p < 3; p++)
        rsel1[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? wsel1 : 5'($urandom_range(0, 31));
      we2    = 1'($urandom_range(0, 1));
      wsel2  = 5'($urandom_range(0, 31));
      wdata2 = 16'($urandom);
      for (int p = 0; p < 2; p++)
        rsel2[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? wsel2 : 5'($urandom_range(0, 31));
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
